fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer for the ARM RISC core. It owns the program counter and drives the address port of the combinational `instruction_memory`. Each returned word is captured together with its PC into a small prefetch FIFO, which feeds decode through a valid/ready handshake. It also handles branch redirects, which flush the FIFO, and a fetch-enable gate for halting.

## Interface
- `RESET_PC`, default 32'h00000000: PC value loaded on reset. Must be word-aligned.
- `DEPTH`, default 2: prefetch FIFO entries. Legal values are 2 to 8, power of two.

- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `fetch_en`, input, 1: when 0, no new fetch is issued. The FIFO still drains.
- `imem_addr`, output, 32: address to `instruction_memory.address`. Equal to PC (combinational from the PC register).
- `imem_instr`, input, 32: from `instruction_memory.instruction`. Valid in the same cycle as `imem_addr`.
- `redirect`, input, 1: branch/exception redirect request, single-cycle pulse.
- `redirect_pc`, input, 32: redirect target.
- `out_valid`, output, 1: FIFO head holds an instruction.
- `out_ready`, input, 1: decode accepts the head this cycle.
- `out_instr`, output, 32: head instruction word.
- `out_pc`, output, 32: head instruction address.
- `align_err`, output, 1: one-cycle pulse, registered. Set when an accepted redirect target has nonzero bits [1:0].

## Operation
- **State**
  - `pc` (32b).
  - FIFO storage of DEPTH × {pc, instr}.
  - Read pointer, write pointer and count, each sized for DEPTH. The count is width $clog2(DEPTH)+1.
  - `align_err` register.
- **Derived signals**
  - pop = out_valid & out_ready.
  - fetch = fetch_en & !redirect & (count < DEPTH | pop).
- **Fetch cycle** (fetch = 1)
  - Write {pc, imem_instr} at the write pointer and advance it.
  - Update pc <= pc + 32'd4. The addition is modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
- **Pop**: advance the read pointer.
- **Count update**: count += fetch − pop. Simultaneous fetch and pop on a full FIFO is legal and leaves count = DEPTH.
- **Redirect** (redirect = 1) has priority over everything else:
  - count, read pointer and write pointer are cleared to 0.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - align_err <= |redirect_pc[1:0].
  - No write happens that cycle. out_ready is ignored for accounting, though decode must discard the head in the flushed cycle.
  - A redirect while fetch_en = 0 still loads pc and flushes.
- **Outputs**
  - out_valid = (count != 0).
  - out_instr and out_pc come from the entry at the read pointer.
  - When empty, the data outputs hold the stale entry and are don't-care.
- **Reset values**
  - pc = RESET_PC, so imem_addr = RESET_PC.
  - count = 0 and both pointers = 0, so out_valid = 0.
  - align_err = 0.
  - FIFO storage is not reset.
- **Reset mid-operation**: the asynchronous assertion immediately forces the reset values, and all in-flight FIFO contents are lost. After deassertion, the first fetch is issued on the first rising edge.

## Timing
- **Fetch latency**: the address is presented in cycle N. The instruction is captured at the end of N and appears on out_* with out_valid = 1 in cycle N+1.
- **After reset**: out_valid first rises one cycle after the first edge with fetch_en = 1, with out_pc = RESET_PC.
- **Redirect**:
  - Redirect asserted in cycle N: out_valid = 0 in N+1.
  - imem_addr = target in N+1.
  - The target instruction appears with out_valid = 1 in N+2, provided fetch_en = 1 in N+1.
- **Throughput**: one instruction per cycle when out_ready is held at 1.
- **Backpressure**: with out_ready = 0 the FIFO fills in DEPTH cycles, and pc then holds.
- **Stability**: out_instr and out_pc stay stable while out_valid = 1 and out_ready = 0, unless a redirect occurs.
- **align_err**: asserted in cycle N+1 for a misaligned redirect in cycle N, for exactly one cycle.

## Test plan
- **Reset and straight-line fetch**: reset, fetch_en = 1, out_ready = 1, memory words 0xE3A00001, 0xE3A01002, 0xE0802001 at addresses 0/4/8.
  - out_pc must be 0, 4, 8 on consecutive cycles with the matching words.
  - out_valid must first be 1 in the first cycle after reset release.
- **Backpressure with DEPTH = 2**:
  - Hold out_ready = 0 for 5 cycles. count must saturate at 2, imem_addr must hold at 8, and out_pc must stay 0.
  - Release: the bench must receive 0, 4, 8, 12 in order with no duplicate or gap.
- **Redirect flush**: with 2 entries buffered, pulse redirect with redirect_pc = 0x40.
  - Next cycle: out_valid = 0 and imem_addr = 0x40.
  - Following cycle: out_pc = 0x40.
  - The stale entries at 0 and 4 must never be accepted.
- **Misaligned redirect**: redirect_pc = 0x47 must give pc = 0x44 and align_err = 1 for exactly one cycle, then 0.
- **Wrap-around**: redirect to 0xFFFFFFFC, then the subsequent out_pc sequence must be 0xFFFFFFFC, 0x00000000.
- **Simultaneous events and mid-run reset**:
  - With a full FIFO and pop and fetch in the same cycle, count must stay 2 and ordering must be preserved.
  - redirect together with out_ready = 1 must produce the flush behaviour only.
  - Asserting reset between clock edges must drop out_valid to 0 and imem_addr to RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, captures {pc, instr} into a prefetch FIFO, handles redirect flush.
// Latency: address presented in cycle N appears on out_* in N+1; redirect target appears in N+2.
// Backpressure: out_ready low fills the FIFO in DEPTH cycles, after which the PC holds; fetch_en low only stops new fetches.
//
// Ports: clk/reset (async active-high); fetch_en gates new fetches; imem_addr/imem_instr talk to the
// combinational instruction memory; redirect/redirect_pc load a new PC and flush; out_valid/out_ready/
// out_instr/out_pc are the decode-side handshake; align_err pulses for one cycle on a misaligned redirect.

// Generic FIFO: DEPTH-entry ring buffer with synchronous flush.
// Latency: written word is visible at the head the cycle after the write.
// Backpressure: the writer must only assert wr_vld when !full or when the head is popped in the same cycle.
module fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             pop;

    assign rd_vld = (count != '0);
    assign full   = (count == CW'(DEPTH));
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld & rd_rdy;

    // Flush wins over both push and pop; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({wr_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_vld && !flush) mem[wr_ptr] <= wr_dat;
    end
endmodule

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        align_err
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic [31:0] pc;
    entry_t      wr_ent;
    entry_t      rd_ent;
    logic        fifo_full;
    logic        pop;
    logic        fetch_vld;

    assign imem_addr = pc;
    assign pop       = out_valid & out_ready;
    // A full FIFO can still take a fetch when the head leaves in the same cycle.
    assign fetch_vld = fetch_en & ~redirect & (~fifo_full | pop);
    assign wr_ent    = '{pc: pc, instr: imem_instr};
    assign out_instr = rd_ent.instr;
    assign out_pc    = rd_ent.pc;

    fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .flush  (redirect),
        .wr_vld (fetch_vld),
        .wr_dat (wr_ent),
        .rd_rdy (out_ready),
        .rd_vld (out_valid),
        .rd_dat (rd_ent),
        .full   (fifo_full)
    );

    // Redirect loads a word-aligned target even while fetch is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= RESET_PC;
            align_err <= 1'b0;
        end else begin
            align_err <= redirect & (|redirect_pc[1:0]);
            if (redirect)
                pc <= {redirect_pc[31:2], 2'b00};
            else if (fetch_vld)
                pc <= pc + 32'd4;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        align_err;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .align_err   (align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory model.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hE3A0_0001;
            32'h0000_0004: return 32'hE3A0_1002;
            32'h0000_0008: return 32'hE080_2001;
            default:       return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected in-order delivery stream starting at a given PC.
    task automatic load_exp(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Scoreboard: every accepted head must be the next expected PC with its memory word.
    always @(negedge clk) begin
        if (!reset && !redirect && out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL accept_unexpected: got pc=%h, none expected", out_pc);
            end else begin
                e = exp_q.pop_front();
                if (out_pc !== e) begin
                    bad++;
                    $display("FAIL accept_pc: got %h, want %h", out_pc, e);
                end
                total++;
                if (out_instr !== mem_word(e)) begin
                    bad++;
                    $display("FAIL accept_instr: got %h, want %h", out_instr, mem_word(e));
                end
                acc_cnt++;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, want 0", out_valid); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h, want 0", imem_addr); end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL rst_align: got %b, want 0", align_err); end
        tick();
        tick();
        fetch_en = 1'b1; out_ready = 1'b1; reset = 1'b0;
        load_exp(32'h0);
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hE3A0_0001) begin
            bad++; $display("FAIL line_0: got v=%b pc=%h i=%h, want 1 0 e3a00001", out_valid, out_pc, out_instr);
        end
        total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL line_addr: got %h, want 4", imem_addr); end
        tick();
        total++; if (out_pc !== 32'h4 || out_instr !== 32'hE3A0_1002) begin
            bad++; $display("FAIL line_4: got pc=%h i=%h, want 4 e3a01002", out_pc, out_instr);
        end
        tick();
        total++; if (out_pc !== 32'h8 || out_instr !== 32'hE080_2001) begin
            bad++; $display("FAIL line_8: got pc=%h i=%h, want 8 e0802001", out_pc, out_instr);
        end
    endtask

    task automatic test_backpressure();
        int acc0;
        reset = 1'b1; out_ready = 1'b0; fetch_en = 1'b1;
        tick();
        reset = 1'b0;
        load_exp(32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
                bad++; $display("FAIL bp_hold_%0d: got v=%b pc=%h, want 1 0", i, out_valid, out_pc);
            end
        end
        total++; if (dut.u_fifo.count !== 2'd2) begin bad++; $display("FAIL bp_count: got %0d, want 2", dut.u_fifo.count); end
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_addr: got %h, want 8", imem_addr); end
        out_ready = 1'b1;
        acc0 = acc_cnt;
        tick();
        // Full FIFO with pop and fetch together keeps the count at DEPTH.
        total++; if (dut.u_fifo.count !== 2'd2 || out_pc !== 32'h4) begin
            bad++; $display("FAIL full_popfetch: got cnt=%0d pc=%h, want 2 4", dut.u_fifo.count, out_pc);
        end
        tick(); tick(); tick();
        total++; if (acc_cnt - acc0 !== 4) begin bad++; $display("FAIL bp_release: got %0d accepts, want 4", acc_cnt - acc0); end
    endtask

    task automatic test_redirect();
        out_ready = 1'b0;
        tick(); tick(); tick();
        total++; if (dut.u_fifo.count !== 2'd2) begin bad++; $display("FAIL rd_prefill: got %0d, want 2", dut.u_fifo.count); end
        redirect = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        load_exp(32'h40);
        tick();
        redirect = 1'b0;
        total++; if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
            bad++; $display("FAIL rd_flush: got v=%b addr=%h, want 0 40", out_valid, imem_addr);
        end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL rd_align: got %b, want 0", align_err); end
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin
            bad++; $display("FAIL rd_target: got v=%b pc=%h, want 1 40", out_valid, out_pc);
        end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_pc = 32'h47;
        load_exp(32'h44);
        tick();
        redirect = 1'b0;
        total++; if (imem_addr !== 32'h44 || align_err !== 1'b1) begin
            bad++; $display("FAIL mis_first: got addr=%h err=%b, want 44 1", imem_addr, align_err);
        end
        tick();
        total++; if (align_err !== 1'b0 || out_pc !== 32'h44) begin
            bad++; $display("FAIL mis_second: got err=%b pc=%h, want 0 44", align_err, out_pc);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        load_exp(32'hFFFF_FFFC);
        tick();
        redirect = 1'b0;
        total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h, want fffffffc", imem_addr); end
        tick();
        total++; if (out_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
            bad++; $display("FAIL wrap_top: got pc=%h addr=%h, want fffffffc 0", out_pc, imem_addr);
        end
        tick();
        total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL wrap_zero: got %h, want 0", out_pc); end
    endtask

    task automatic test_halt();
        fetch_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        load_exp(32'h100);
        tick();
        redirect = 1'b0;
        total++; if (imem_addr !== 32'h100 || out_valid !== 1'b0) begin
            bad++; $display("FAIL halt_redirect: got addr=%h v=%b, want 100 0", imem_addr, out_valid);
        end
        tick(); tick(); tick();
        total++; if (imem_addr !== 32'h100 || out_valid !== 1'b0) begin
            bad++; $display("FAIL halt_hold: got addr=%h v=%b, want 100 0", imem_addr, out_valid);
        end
        fetch_en = 1'b1;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
            bad++; $display("FAIL halt_resume: got v=%b pc=%h, want 1 100", out_valid, out_pc);
        end
    endtask

    task automatic test_mid_reset();
        tick(); tick();
        #2;
        reset = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
            bad++; $display("FAIL async_reset: got v=%b addr=%h, want 0 0", out_valid, imem_addr);
        end
        load_exp(32'h0);
        reset = 1'b0;
        tick();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++; $display("FAIL post_reset0: got v=%b pc=%h, want 1 0", out_valid, out_pc);
        end
        tick();
        total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL post_reset4: got %h, want 4", out_pc); end
        tick();
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_halt();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
